// File: rtl/axicb_mst_cpl_route.sv
// Completion router for one slave port and one direction: decodes the master from the
// completion ID, forwards through a one-stage register, and tracks slave outstanding requests.
module axicb_mst_cpl_route #(
   parameter int                            RD_PATH         = 0,
   parameter int                            AXI_ID_W        = 8,
   parameter int                            MST_NB          = 4,
   parameter int                            SLV_OSTDREQ_NUM = 4,
   parameter logic [AXI_ID_W-1:0]           MST_ID_SEL      = 'hF0,
   parameter logic [MST_NB*AXI_ID_W-1:0]    MST_ID_MASKS    = {8'h40, 8'h30, 8'h20, 8'h10},
   parameter int                            CCH_W           = 8,
   localparam int                           CNT_W           = $clog2(SLV_OSTDREQ_NUM + 1)
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                a_valid,
   input  logic                a_ready,
   output logic                a_full,
   output logic [CNT_W-1:0]    ostd_cnt,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic                s_last,
   input  logic [CCH_W-1:0]    s_ch,
   output logic [MST_NB-1:0]   m_valid,
   input  logic [MST_NB-1:0]   m_ready,
   output logic                m_last,
   output logic [CCH_W-1:0]    m_ch,
   output logic                err_unk,
   output logic                err_spur,
   output logic                err_ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLV_OSTDREQ_NUM);

   logic [MST_NB-1:0] w_hit;
   logic [MST_NB-1:0] w_sel;
   logic              w_routable;
   logic              w_dlv;
   logic              w_acc;
   logic              w_load;
   logic              w_drop;
   logic              w_eot;
   logic              w_inc;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              w_ovf;
   logic              w_spur;

   logic              r_out_v;
   logic [MST_NB-1:0] r_out_sel;
   logic              r_last;
   logic [CCH_W-1:0]  r_ch;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_full;
   logic              r_err_unk;
   logic              r_err_spur;
   logic              r_err_ovf;

   for (genvar gi = 0; gi < MST_NB; gi++) begin : g_hit
      assign w_hit[gi] = ((s_ch[AXI_ID_W-1:0] & MST_ID_SEL) == MST_ID_MASKS[gi*AXI_ID_W +: AXI_ID_W]);
   end

   // Overlapping masks resolve to the lowest master index.
   always_comb begin
      w_sel = '0;
      for (int i = MST_NB - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_sel    = '0;
            w_sel[i] = 1'b1;
         end
      end
   end

   assign w_routable = |w_hit;
   assign w_dlv      = r_out_v & |(r_out_sel & m_ready);
   assign s_ready    = !r_out_v | w_dlv;
   assign w_acc      = s_valid & s_ready;
   assign w_load     = w_acc & w_routable;
   assign w_drop     = w_acc & !w_routable;
   assign w_inc      = a_valid & a_ready;

   if (RD_PATH != 0) begin : g_rd
      assign w_eot = (w_dlv & r_last) | (w_drop & s_last);
   end else begin : g_wr
      assign w_eot = w_dlv | w_drop;
   end

   // A request and a completion in the same cycle cancel out.
   always_comb begin
      w_cnt_next = r_cnt;
      w_ovf      = 1'b0;
      w_spur     = 1'b0;
      if (w_inc && !w_eot) begin
         if (r_cnt == CNT_MAX) w_ovf = 1'b1;
         else                  w_cnt_next = r_cnt + CNT_W'(1);
      end else if (w_eot && !w_inc) begin
         if (r_cnt == '0) w_spur = 1'b1;
         else             w_cnt_next = r_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_out_v    <= 1'b0;
         r_out_sel  <= '0;
         r_last     <= 1'b0;
         r_ch       <= '0;
         r_cnt      <= '0;
         r_full     <= 1'b0;
         r_err_unk  <= 1'b0;
         r_err_spur <= 1'b0;
         r_err_ovf  <= 1'b0;
      end else begin
         if (w_load) begin
            r_out_v   <= 1'b1;
            r_out_sel <= w_sel;
            r_last    <= s_last;
            r_ch      <= s_ch;
         end else if (w_dlv) begin
            r_out_v   <= 1'b0;
         end
         r_cnt  <= w_cnt_next;
         r_full <= (w_cnt_next == CNT_MAX);
         if (w_drop) r_err_unk  <= 1'b1;
         if (w_spur) r_err_spur <= 1'b1;
         if (w_ovf)  r_err_ovf  <= 1'b1;
      end
   end

   assign m_valid  = r_out_v ? r_out_sel : '0;
   assign m_last   = r_last;
   assign m_ch     = r_ch;
   assign ostd_cnt = r_cnt;
   assign a_full   = r_full;
   assign err_unk  = r_err_unk;
   assign err_spur = r_err_spur;
   assign err_ovf  = r_err_ovf;

endmodule

// File: tb/tb_axicb_mst_cpl_route.sv
// Bench for axicb_mst_cpl_route: a read-path and a write-path instance share stimulus and
// are checked against a cycle-level behavioural model of completions and outstanding count.
module tb_axicb_mst_cpl_route;

   localparam int NM   = 4;
   localparam int IDW  = 8;
   localparam int CW   = 16;
   localparam int MAXO = 4;

   logic          aclk    = 1'b0;
   logic          aresetn = 1'b0;
   logic          a_valid = 1'b0;
   logic          a_ready = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_last  = 1'b0;
   logic [CW-1:0] s_ch    = '0;
   logic [NM-1:0] m_ready = '1;

   logic [NM-1:0] o_mv   [2];
   logic [CW-1:0] o_mch  [2];
   logic          o_ml   [2];
   logic [2:0]    o_cnt  [2];
   logic          o_full [2];
   logic          o_sr   [2];
   logic          o_eu   [2];
   logic          o_es   [2];
   logic          o_eo   [2];

   int n_vec = 0;
   int n_err = 0;

   always #5 aclk = ~aclk;

   // Index 0 is the write path, index 1 the read path.
   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      axicb_mst_cpl_route #(
         .RD_PATH(gi), .AXI_ID_W(IDW), .MST_NB(NM), .SLV_OSTDREQ_NUM(MAXO),
         .MST_ID_SEL(8'hF0), .MST_ID_MASKS({8'h40, 8'h30, 8'h20, 8'h10}), .CCH_W(CW)
      ) u_dut (
         .aclk(aclk), .aresetn(aresetn), .a_valid(a_valid), .a_ready(a_ready),
         .a_full(o_full[gi]), .ostd_cnt(o_cnt[gi]), .s_valid(s_valid), .s_ready(o_sr[gi]),
         .s_last(s_last), .s_ch(s_ch), .m_valid(o_mv[gi]), .m_ready(m_ready),
         .m_last(o_ml[gi]), .m_ch(o_mch[gi]), .err_unk(o_eu[gi]), .err_spur(o_es[gi]),
         .err_ovf(o_eo[gi])
      );
   end

   // Behavioural model: one pending beat per path plus a transaction counter.
   logic [IDW-1:0] masks [NM] = '{8'h10, 8'h20, 8'h30, 8'h40};
   bit             md_v   [2];
   int             md_sel [2];
   logic [CW-1:0]  md_ch  [2];
   bit             md_lst [2];
   int             md_cnt [2];
   bit             md_unk [2];
   bit             md_spur[2];
   bit             md_ovf [2];

   function automatic int decode(input logic [IDW-1:0] id);
      for (int i = 0; i < NM; i++)
         if ((id & 8'hF0) == masks[i]) return i;
      return -1;
   endfunction

   function automatic logic exp_sready(input int p);
      return !md_v[p] || m_ready[md_sel[p]];
   endfunction

   function automatic logic [27:0] exp_state(input int p);
      logic [NM-1:0] mv;
      mv = md_v[p] ? NM'(1 << md_sel[p]) : '0;
      return {mv, md_ch[p], md_lst[p], 3'(md_cnt[p]), md_cnt[p] == MAXO,
              md_unk[p], md_spur[p], md_ovf[p]};
   endfunction

   function automatic logic [27:0] got_state(input int p);
      return {o_mv[p], o_mch[p], o_ml[p], o_cnt[p], o_full[p], o_eu[p], o_es[p], o_eo[p]};
   endfunction

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         md_v[p] = 0; md_sel[p] = 0; md_ch[p] = '0; md_lst[p] = 0; md_cnt[p] = 0;
         md_unk[p] = 0; md_spur[p] = 0; md_ovf[p] = 0;
      end
   endtask

   task automatic model_step();
      int d;
      bit inc, dlv, acc, drop, eot;
      d   = decode(s_ch[IDW-1:0]);
      inc = a_valid && a_ready;
      for (int p = 0; p < 2; p++) begin
         dlv  = md_v[p] && m_ready[md_sel[p]];
         acc  = s_valid && (!md_v[p] || dlv);
         drop = acc && (d < 0);
         eot  = (p == 1) ? ((dlv && md_lst[p]) || (drop && s_last)) : (dlv || drop);
         if (inc && !eot) begin
            if (md_cnt[p] == MAXO) md_ovf[p] = 1; else md_cnt[p]++;
         end else if (eot && !inc) begin
            if (md_cnt[p] == 0) md_spur[p] = 1; else md_cnt[p]--;
         end
         if (drop) md_unk[p] = 1;
         if (acc && d >= 0) begin
            md_v[p] = 1; md_sel[p] = d; md_ch[p] = s_ch; md_lst[p] = s_last;
         end else if (dlv) begin
            md_v[p] = 0;
         end
      end
   endtask

   task automatic tick();
      if (!aresetn) model_reset(); else model_step();
      @(posedge aclk);
      #1;
   endtask

   task automatic idle();
      a_valid = 0; a_ready = 0; s_valid = 0; s_last = 0; s_ch = '0; m_ready = '1;
   endtask

   task automatic do_reset();
      idle();
      aresetn = 0;
      tick();
      tick();
      aresetn = 1;
   endtask

   task automatic test_reset();
      idle();
      aresetn = 0;
      tick();
      tick();
      for (int p = 0; p < 2; p++) begin
         n_vec++;
         if (got_state(p) !== 28'h0) begin
            n_err++;
            $display("FAIL reset_state path%0d got=%h want=0", p, got_state(p));
         end
      end
      aresetn = 1;
      #1;
      for (int p = 0; p < 2; p++) begin
         n_vec++;
         if (o_sr[p] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_sready path%0d got=%b want=1", p, o_sr[p]);
         end
      end
   endtask

   task automatic test_basic_routing();
      logic [CW-1:0] exp;
      do_reset();
      a_valid = 1; a_ready = 1;
      tick();
      a_valid = 0; a_ready = 0;
      for (int b = 0; b < 4; b++) begin
         exp = {8'(8'hA0 + b), 8'h21};
         s_valid = 1; s_ch = exp; s_last = (b == 3);
         tick();
         n_vec++;
         if (o_mv[1] !== 4'b0010 || o_mch[1] !== exp) begin
            n_err++;
            $display("FAIL basic_beat%0d got mv=%b ch=%h want mv=0010 ch=%h", b, o_mv[1], o_mch[1], exp);
         end
      end
      s_valid = 0; s_last = 0;
      n_vec++;
      if (o_cnt[1] !== 3'd1) begin
         n_err++;
         $display("FAIL basic_cnt_before_last got=%0d want=1", o_cnt[1]);
      end
      tick();
      n_vec++;
      if (o_mv[1] !== 4'b0000 || o_cnt[1] !== 3'd0 || o_ml[1] !== 1'b1) begin
         n_err++;
         $display("FAIL basic_after_last got mv=%b cnt=%0d last=%b want mv=0000 cnt=0 last=1",
                  o_mv[1], o_cnt[1], o_ml[1]);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      m_ready = 4'b1110;
      s_valid = 1; s_ch = {8'h5A, 8'h12};
      tick();
      s_ch = {8'hC3, 8'h12};
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (o_sr[1] !== 1'b0) begin
            n_err++;
            $display("FAIL bp_sready%0d got=%b want=0", k, o_sr[1]);
         end
         tick();
         n_vec++;
         if (o_mv[1] !== 4'b0001 || o_mch[1] !== 16'h5A12) begin
            n_err++;
            $display("FAIL bp_hold%0d got mv=%b ch=%h want mv=0001 ch=5a12", k, o_mv[1], o_mch[1]);
         end
      end
      m_ready = '1;
      #1;
      n_vec++;
      if (o_sr[1] !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release_sready got=%b want=1", o_sr[1]);
      end
      tick();
      s_valid = 0;
      n_vec++;
      if (o_mv[1] !== 4'b0001 || o_mch[1] !== 16'hC312) begin
         n_err++;
         $display("FAIL bp_second got mv=%b ch=%h want mv=0001 ch=c312", o_mv[1], o_mch[1]);
      end
      tick();
      n_vec++;
      if (o_mv[1] !== 4'b0000) begin
         n_err++;
         $display("FAIL bp_drain got mv=%b want=0000", o_mv[1]);
      end
   endtask

   task automatic test_full_overflow();
      do_reset();
      a_valid = 1; a_ready = 1;
      for (int k = 0; k < 5; k++) begin
         tick();
         for (int p = 0; p < 2; p++) begin
            n_vec++;
            if (o_cnt[p] !== 3'((k < 4) ? k + 1 : 4) || o_full[p] !== (k >= 3) || o_eo[p] !== (k == 4)) begin
               n_err++;
               $display("FAIL full_step%0d path%0d got cnt=%0d full=%b ovf=%b", k, p, o_cnt[p], o_full[p], o_eo[p]);
            end
         end
      end
      idle();
   endtask

   task automatic test_simultaneous();
      do_reset();
      a_valid = 1; a_ready = 1;
      tick();
      tick();
      a_valid = 0; a_ready = 0;
      s_valid = 1; s_ch = {8'h77, 8'h31}; s_last = 1;
      tick();
      s_valid = 0; s_last = 0; a_valid = 1; a_ready = 1;
      tick();
      a_valid = 0; a_ready = 0;
      for (int p = 0; p < 2; p++) begin
         n_vec++;
         if (o_cnt[p] !== 3'd2 || {o_eu[p], o_es[p], o_eo[p]} !== 3'b000 || o_mv[p] !== 4'b0000) begin
            n_err++;
            $display("FAIL simul path%0d got cnt=%0d err=%b%b%b mv=%b want cnt=2 err=000 mv=0000",
                     p, o_cnt[p], o_eu[p], o_es[p], o_eo[p], o_mv[p]);
         end
      end
   endtask

   task automatic test_unroutable_spurious();
      do_reset();
      a_valid = 1; a_ready = 1;
      tick();
      a_valid = 0; a_ready = 0;
      s_valid = 1; s_ch = {8'hEE, 8'h05}; s_last = 1;
      #1;
      for (int p = 0; p < 2; p++) begin
         n_vec++;
         if (o_sr[p] !== 1'b1) begin
            n_err++;
            $display("FAIL unk_sready path%0d got=%b want=1", p, o_sr[p]);
         end
      end
      tick();
      s_valid = 0;
      for (int p = 0; p < 2; p++) begin
         n_vec++;
         if (o_mv[p] !== 4'b0000 || o_eu[p] !== 1'b1 || o_cnt[p] !== 3'd0 || o_es[p] !== 1'b0) begin
            n_err++;
            $display("FAIL unk_drop path%0d got mv=%b unk=%b cnt=%0d spur=%b", p, o_mv[p], o_eu[p], o_cnt[p], o_es[p]);
         end
      end
      s_valid = 1; s_ch = {8'h99, 8'h41}; s_last = 1;
      tick();
      s_valid = 0; s_last = 0;
      for (int p = 0; p < 2; p++) begin
         n_vec++;
         if (o_mv[p] !== 4'b1000 || o_mch[p] !== 16'h9941) begin
            n_err++;
            $display("FAIL spur_fwd path%0d got mv=%b ch=%h want mv=1000 ch=9941", p, o_mv[p], o_mch[p]);
         end
      end
      tick();
      for (int p = 0; p < 2; p++) begin
         n_vec++;
         if (o_es[p] !== 1'b1 || o_cnt[p] !== 3'd0 || o_mv[p] !== 4'b0000) begin
            n_err++;
            $display("FAIL spur_flag path%0d got spur=%b cnt=%0d mv=%b want spur=1 cnt=0 mv=0000",
                     p, o_es[p], o_cnt[p], o_mv[p]);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      s_valid = 1; s_ch = {8'h11, 8'h05}; s_last = 0;
      tick();
      s_valid = 0;
      a_valid = 1; a_ready = 1;
      tick(); tick(); tick();
      a_valid = 0; a_ready = 0;
      m_ready = '0;
      s_valid = 1; s_ch = {8'h42, 8'h21};
      tick();
      s_valid = 0;
      for (int p = 0; p < 2; p++) begin
         n_vec++;
         if (o_mv[p] !== 4'b0010 || o_cnt[p] !== 3'd3 || o_eu[p] !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre path%0d got mv=%b cnt=%0d unk=%b want mv=0010 cnt=3 unk=1",
                     p, o_mv[p], o_cnt[p], o_eu[p]);
         end
      end
      aresetn = 0;
      tick();
      aresetn = 1;
      m_ready = '1;
      for (int p = 0; p < 2; p++) begin
         n_vec++;
         if (got_state(p) !== 28'h0 || o_sr[p] !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_post path%0d got=%h sready=%b want=0 sready=1", p, got_state(p), o_sr[p]);
         end
      end
      tick();
      for (int p = 0; p < 2; p++) begin
         n_vec++;
         if (got_state(p) !== 28'h0) begin
            n_err++;
            $display("FAIL rstmid_clean path%0d got=%h want=0", p, got_state(p));
         end
      end
   endtask

   task automatic test_random();
      logic [IDW-1:0] id;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         aresetn = ($urandom_range(0, 79) != 0);
         a_valid = 1'($urandom);
         a_ready = 1'($urandom);
         s_valid = ($urandom_range(0, 3) != 0);
         s_last  = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 9) < 7) id = {4'($urandom_range(1, 4)), 4'($urandom)};
         else                          id = 8'($urandom);
         s_ch = {8'($urandom), id};
         for (int i = 0; i < NM; i++) m_ready[i] = ($urandom_range(0, 3) != 0);
         #1;
         for (int p = 0; p < 2; p++) begin
            n_vec++;
            if (o_sr[p] !== exp_sready(p)) begin
               n_err++;
               $display("FAIL rand_sready cyc%0d path%0d got=%b want=%b", cyc, p, o_sr[p], exp_sready(p));
            end
         end
         tick();
         for (int p = 0; p < 2; p++) begin
            n_vec++;
            if (got_state(p) !== exp_state(p)) begin
               n_err++;
               $display("FAIL rand_state cyc%0d path%0d got=%h want=%h", cyc, p, got_state(p), exp_state(p));
            end
         end
      end
      aresetn = 1;
      idle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic_routing();
      test_backpressure();
      test_full_overflow();
      test_simultaneous();
      test_unroutable_spurious();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axicb_mst_cpl_route.md
# axicb_mst_cpl_route

Completion router placed on the slave-facing side of the crossbar, one instance per slave port and per direction (read or write). It takes the completion stream (R or B) returned by one slave, decodes the originating master from the completion ID, and forwards it through a one-stage registered pipeline to that master's completion input. It also keeps the slave's outstanding-request count and flags spurious, overflowing or unroutable traffic.

## Interface
- RD_PATH, 0: 1 = read completions (last beat ends a transaction); 0 = write completions (every beat ends one, `s_last` ignored).
- AXI_ID_W, 8: ID width in bits.
- MST_NB, 4: number of masters (1..8).
- SLV_OSTDREQ_NUM, 4: maximum outstanding requests toward the slave (≥1).
- MST_ID_SEL, 'hF0: ID bits that select the master.
- MST_ID_MASKS, {'h40,'h30,'h20,'h10}: MST_NB×AXI_ID_W packed vector. Master i owns an ID when (id & MST_ID_SEL) == MST_ID_MASKS[i].
- CCH_W, 8: completion channel width. The ID is in bits [AXI_ID_W-1:0].

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low, sampled on rising aclk.
- a_valid  in  1  address valid toward the slave.
- a_ready  in  1  address ready from the slave.
- a_full  out  1  outstanding count == SLV_OSTDREQ_NUM. Upstream must stop granting.
- ostd_cnt  out  $clog2(SLV_OSTDREQ_NUM+1)  current outstanding count.
- s_valid  in  1  completion valid from the slave.
- s_ready  out  1  completion ready to the slave.
- s_last  in  1  last beat (read path only).
- s_ch  in  CCH_W  completion payload.
- m_valid  out  MST_NB  one-hot completion valid, one bit per master.
- m_ready  in  MST_NB  ready from each master.
- m_last  out  1  registered last.
- m_ch  out  CCH_W  registered payload, shared by all masters.
- err_unk  out  1  sticky: a completion ID matched no master.
- err_spur  out  1  sticky: a transaction ended while the count was 0.
- err_ovf  out  1  sticky: an address was accepted while a_full was high.

## Operation
- **Decode.** Compute `hit[i]` for each master from s_ch[AXI_ID_W-1:0] using the mask rule.
  - If more than one bit of `hit` is set, the lowest index wins.
  - If no bit is set, the ID is unroutable.
- **Output register.** State is out_v, out_sel (one-hot), m_last, m_ch.
  - m_valid = out_sel when out_v is 1, otherwise 0.
  - Delivery occurs when out_v & |(m_valid & m_ready).
  - s_ready = !out_v | delivery.
  - On s_valid & s_ready with a routable ID: load payload, load sel, set out_v = 1.
  - On s_valid & s_ready with an unroutable ID: the beat is consumed and dropped, the register is not loaded, and err_unk is set.
  - On delivery with no new load: out_v = 0.
- **End-of-transaction event (`eot`).**
  - Read path: a delivered beat with m_last = 1, or a dropped beat with s_last = 1.
  - Write path: every delivered or dropped beat.
- **Outstanding counter.** Increment event `inc` = a_valid & a_ready.
  - inc & !eot: the count increments. If the count already equals SLV_OSTDREQ_NUM, it holds and err_ovf is set.
  - eot & !inc: the count decrements. If the count is 0, it holds at 0 and err_spur is set.
  - inc & eot on the same cycle: the count is unchanged and no error is raised.
- The counter does not alter routing. Spurious completions are still forwarded.

## Timing
- **Reset values:** out_v = 0, m_valid = 0, m_last = 0, m_ch = 0, ostd_cnt = 0, a_full = 0, all err_* = 0.
- s_ready = 1 in the first cycle after reset is released.
- **Latency:** a beat accepted in cycle N is presented on m_valid/m_ch in cycle N+1.
- **Throughput:** one beat per cycle while the selected m_ready stays high.
- Once m_valid is asserted, m_valid, m_ch and m_last hold stable until delivery.
- s_ready depends combinationally on m_ready. There is no combinational path from s_* to m_*.
- a_full is a registered compare. It rises in the cycle after the increment that reaches the limit.
- Error flags rise in the cycle after the causing event and clear only on reset.
- **Reset mid-burst:** an in-flight register is discarded, counters clear, and the next cycle is clean.

## Test plan
- **Basic routing:** RD_PATH=1, default masks, 4-beat burst with ID 'h21 and m_ready all 1 → m_valid = 4'b0010 for 4 consecutive cycles, one cycle after each s beat; ostd_cnt goes 1 → 0 on the last beat.
- **Backpressure:** m_ready[0] = 0 for 3 cycles while ID 'h12 is pending → m_valid = 4'b0001 and m_ch are stable, s_ready = 0, no beat is lost or duplicated.
- **Full and overflow:** SLV_OSTDREQ_NUM=4, 4 address handshakes → a_full = 1, ostd_cnt = 4; a 5th handshake → err_ovf = 1, ostd_cnt stays 4.
- **Simultaneous events:** RD_PATH=0, ostd_cnt = 2, a_valid & a_ready in the same cycle as a B delivery → ostd_cnt stays 2, no error flag.
- **Unroutable and spurious:**
  - ID 'h05 → beat dropped with s_ready = 1, m_valid stays 0, err_unk = 1, ostd_cnt decrements.
  - A B beat with ostd_cnt = 0 → err_spur = 1, beat still forwarded.
- **Reset mid-operation:** assert aresetn = 0 while out_v = 1 and ostd_cnt = 3 → next cycle m_valid = 0, ostd_cnt = 0, all error flags = 0.
